// File: rtl/binary_mul_acc_5.sv
// Accumulation stage for the 5x5 multiplier product stream: sums a frame of
// unsigned terms with saturation and presents the result over valid/ready.
module binary_mul_acc_5 #(
  parameter int P_W     = 10,
  parameter int ACC_W   = 12,
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [P_W-1:0]   p_in,
  input  logic             p_valid,
  input  logic             p_last,
  output logic             in_ready,
  output logic [ACC_W-1:0] sum,
  output logic [CNT_W-1:0] sum_count,
  output logic             sum_ovf,
  output logic             sum_valid,
  input  logic             sum_ready
);

  typedef enum logic {ACC, OUT} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             flag;

  logic [ACC_W:0]   raw;
  logic [ACC_W-1:0] acc_nxt;
  logic             step_ovf;
  logic [CNT_W-1:0] count_nxt;
  logic             beat;
  logic             frame_end;

  assign in_ready = en & (state == ACC);

  // One extra bit on the adder exposes the carry that signals saturation.
  always_comb begin
    raw       = {1'b0, acc} + {{(ACC_W + 1 - P_W){1'b0}}, p_in};
    step_ovf  = raw[ACC_W];
    acc_nxt   = step_ovf ? '1 : raw[ACC_W-1:0];
    count_nxt = count + CNT_W'(1);
    beat      = p_valid & in_ready;
    frame_end = p_last | (count_nxt == CNT_W'(MAX_LEN));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACC;
      acc       <= '0;
      count     <= '0;
      flag      <= 1'b0;
      sum       <= '0;
      sum_count <= '0;
      sum_ovf   <= 1'b0;
      sum_valid <= 1'b0;
    end else if (en) begin
      case (state)
        ACC: begin
          if (beat) begin
            if (frame_end) begin
              sum       <= acc_nxt;
              sum_count <= count_nxt;
              sum_ovf   <= flag | step_ovf;
              sum_valid <= 1'b1;
              acc       <= '0;
              count     <= '0;
              flag      <= 1'b0;
              state     <= OUT;
            end else begin
              acc   <= acc_nxt;
              count <= count_nxt;
              flag  <= flag | step_ovf;
            end
          end
        end
        OUT: begin
          if (sum_ready) begin
            sum_valid <= 1'b0;
            state     <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_binary_mul_acc_5.sv
// Scoreboard bench for binary_mul_acc_5: directed scenarios plus randomized
// frames checked against an arithmetic frame-sum reference model.
module tb_binary_mul_acc_5;

  localparam int P_W     = 10;
  localparam int ACC_W   = 12;
  localparam int MAX_LEN = 16;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);
  localparam int SAT     = (1 << ACC_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [P_W-1:0]   p_in;
  logic             p_valid;
  logic             p_last;
  logic             in_ready;
  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] sum_count;
  logic             sum_ovf;
  logic             sum_valid;
  logic             sum_ready;

  binary_mul_acc_5 #(.P_W(P_W), .ACC_W(ACC_W), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .p_in(p_in), .p_valid(p_valid),
    .p_last(p_last), .in_ready(in_ready), .sum(sum), .sum_count(sum_count),
    .sum_ovf(sum_ovf), .sum_valid(sum_valid), .sum_ready(sum_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned s;
    int unsigned c;
    int unsigned o;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned frame_terms[$];
  int          checks   = 0;
  int          failures = 0;
  bit          rand_on  = 1'b0;

  task automatic chk(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: a frame is just the list of accepted terms; its result is
  // the plain integer sum clipped to the accumulator range.
  task automatic model_accept(input int unsigned t, input bit last, output bit fend);
    exp_t        e;
    int unsigned tot;
    frame_terms.push_back(t);
    fend = last || (frame_terms.size() == MAX_LEN);
    if (fend) begin
      tot = 0;
      foreach (frame_terms[i]) tot += frame_terms[i];
      e.s = (tot > SAT) ? SAT : tot;
      e.c = frame_terms.size();
      e.o = (tot > SAT) ? 1 : 0;
      exp_q.push_back(e);
      frame_terms.delete();
    end
  endtask

  // Called at posedge+1 right after the edge that accepted term t.
  task automatic finish_beat(input int unsigned t, input bit last);
    bit fend;
    p_valid = 1'b0;
    p_last  = 1'($urandom);
    p_in    = P_W'($urandom);
    model_accept(t, last, fend);
    if (fend) begin
      @(negedge clk);
      chk("frame_end_valid", sum_valid, 1);
      chk("frame_end_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
  endtask

  // Present one term and hold it until accepted; starts and ends at posedge+1.
  task automatic send(input int unsigned t, input bit last);
    bit done = 1'b0;
    int n    = 0;
    p_valid = 1'b1;
    p_in    = P_W'(t);
    p_last  = last;
    while (!done && n < 300) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!done) begin
      chk("accept_timeout", 0, 1);
      p_valid = 1'b0;
    end else begin
      finish_beat(t, last);
    end
  endtask

  // Monitor: a presented result must equal the scoreboard head, popped on handshake.
  always @(negedge clk) begin
    if (rst_n && sum_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        chk("sum", sum, exp_q[0].s);
        chk("sum_count", sum_count, exp_q[0].c);
        chk("sum_ovf", sum_ovf, exp_q[0].o);
        if (sum_ready && en) void'(exp_q.pop_front());
      end
    end
  end

  // Random enable / backpressure while the random phase runs.
  initial begin
    wait (rand_on);
    while (rand_on) begin
      @(posedge clk); #1;
      if (rand_on) begin
        en        = ($urandom_range(7) != 0);
        sum_ready = ($urandom_range(2) != 0);
      end
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; p_valid = 1'b1; p_in = 10'd100; p_last = 1'b0; sum_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sum", sum, 0);
    chk("rst_count", sum_count, 0);
    chk("rst_ovf", sum_ovf, 0);
    chk("rst_valid", sum_valid, 0);
    @(posedge clk); #1;
    p_valid = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Basic frame then backpressure with a term waiting.
    send(6, 0); send(15, 0); send(100, 1);
    chk("basic_sum", sum, 121);
    p_valid = 1'b1; p_in = 10'd9; p_last = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_sum_hold", sum, 121);
      @(posedge clk); #1;
    end
    sum_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_before_hs", sum_valid, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("hs_valid_low", sum_valid, 0);
    chk("hs_sum_retained", sum, 121);
    chk("hs_in_ready", in_ready, 1);
    @(posedge clk); #1;
    finish_beat(9, 1);

    // Saturation then a clean frame.
    repeat (4) send(961, 0);
    send(961, 1);
    chk("sat_sum", sum, SAT);
    chk("sat_ovf", sum_ovf, 1);
    send(7, 1);

    // Max length cut, then a single-term frame.
    repeat (16) send(1, 0);
    chk("maxlen_count", sum_count, 16);
    send(3, 1);

    // Enable freeze mid-frame.
    send(5, 0); send(5, 0);
    en = 1'b0; p_valid = 1'b1; p_in = 10'd5; p_last = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("en_off_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    en = 1'b1;
    send(5, 1);
    chk("en_frame_sum", sum, 15);

    // Mid-frame reset discards the partial frame.
    send(5, 0); send(5, 0);
    rst_n = 1'b0;
    frame_terms.delete();
    #2;
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_valid", sum_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(4, 1);
    chk("post_rst_count", sum_count, 1);

    // Randomized frames, with lengths that sometimes exceed MAX_LEN.
    rand_on = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int unsigned len = $urandom_range(1, 20);
      for (int unsigned k = 0; k < len; k++) begin
        int unsigned t = ($urandom_range(1) != 0) ? $urandom_range(1023)
                                                  : $urandom_range(31) * $urandom_range(31);
        send(t, k == len - 1);
        repeat ($urandom_range(3) == 0 ? 1 : 0) @(posedge clk);
        #1;
      end
    end
    rand_on = 1'b0;
    @(posedge clk); #1;
    en = 1'b1; sum_ready = 1'b1;

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("no_partial_frame", frame_terms.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/binary_mul_acc_5.md
# binary_mul_acc_5

Downstream accumulation stage for the 5x5 unsigned registered multiplier. It consumes the multiplier's 10-bit product stream one term per cycle and sums a frame of terms into a dot-product result. A frame ends on a last flag or at a maximum length. The result is presented on a valid/ready output handshake with a saturation flag.

## Interface

Parameters:
- P_W, 10, product input width (multiplier P output width).
- ACC_W, 12, accumulator/result width; must be >= P_W.
- MAX_LEN, 16, maximum terms per frame; forced frame end at this count.
- CNT_W, $clog2(MAX_LEN+1), term-count width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  global enable; when 0 all registers hold and no handshake completes.
- p_in  in  P_W  product term, unsigned.
- p_valid  in  1  p_in valid this cycle.
- p_last  in  1  p_in is the final term of the frame; qualified by p_valid.
- in_ready  out  1  stage accepts a term this cycle.
- sum  out  ACC_W  frame result, unsigned, saturated.
- sum_count  out  CNT_W  number of terms in the frame result.
- sum_ovf  out  1  frame result saturated.
- sum_valid  out  1  result valid.
- sum_ready  in  1  downstream takes result.

## Operation

- Two states:
  - ACC (reset state).
  - OUT.
- Combinational in_ready = en & (state==ACC).
- Term accept: beat = p_valid & in_ready.
- ACC, on beat:
  - next = acc + zero-extend(p_in). If the true sum exceeds 2^ACC_W-1, next = all-ones and the frame overflow flag is set (sticky until frame end).
  - count += 1.
  - If p_last, or count+1 == MAX_LEN: latch sum=next, sum_count=count+1, sum_ovf=(flag | this overflow); set sum_valid=1; clear acc, count and flag; go to OUT.
  - Otherwise acc=next and stay in ACC.
- ACC, no beat: hold.
- OUT:
  - in_ready=0. sum, sum_count and sum_ovf are held stable while sum_valid=1.
  - On en & sum_ready: sum_valid=0, go to ACC. sum, sum_count and sum_ovf retain their last values.
- en=0: state, acc, count, flag and outputs frozen. sum_ready is ignored.
- p_last without p_valid is ignored.
- Reset (asynchronous, any state, including mid-frame):
  - state=ACC; acc=0, count=0, flag=0.
  - sum=0, sum_count=0, sum_ovf=0, sum_valid=0.
  - in_ready follows en once rst_n is high.
  - Any partial frame is discarded.

## Timing

- Throughput: one term per cycle within a frame.
- Frame-end latency: sum_valid rises on the edge that accepts the final term, so it is visible the cycle after that beat.
- Inter-frame gap: at least one cycle with in_ready=0 (OUT state). With sum_ready held high, the next term is accepted 2 cycles after the final term.
- Output handshake completes on the edge where sum_valid & sum_ready & en. sum_ready may be high before sum_valid.
- Upstream pairing: the multiplier's P is valid one cycle after A/B are applied with en=1. The upstream wrapper delays its operand-valid by one cycle to form p_valid.
- No combinational path from p_valid or sum_ready to any output. in_ready depends only on state and en.

## Test plan

- Reset: rst_n=0 with p_valid=1, p_in=100 -> sum=0, sum_count=0, sum_ovf=0, sum_valid=0. After release with en=1 -> in_ready=1.
- Basic frame: terms 6, 15, 100 on consecutive cycles, p_last on 100 -> next cycle sum=121, sum_count=3, sum_ovf=0, sum_valid=1, in_ready=0. Inputs are 2x3, 3x5 and 10x10 products taken from the multiplier.
- Backpressure: hold sum_ready=0 for 4 cycles after the basic frame while driving p_valid=1, p_in=9 -> sum stays 121 and in_ready stays 0, so no term is accepted. Assert sum_ready -> sum_valid=0 next cycle, then term 9 is accepted.
- Saturation: five terms of 961 (31x31), p_last on the fifth -> sum=4095, sum_count=5, sum_ovf=1. Next frame is a single term 7 with p_last -> sum=7, sum_ovf=0.
- Max length: sixteen terms of 1, p_last never asserted -> after the 16th beat sum=16, sum_count=16. After the handshake, a 17th term of 3 with p_last -> sum=3, sum_count=1.
- en and mid-frame reset:
  - Two terms 5, 5, then en=0 for 3 cycles while p_valid=1 -> no accept, state frozen. en=1 then term 5 with p_last -> sum=15.
  - Repeat with rst_n pulsed low after two terms -> partial frame dropped. Term 4 with p_last -> sum=4, sum_count=1.
